// File: rtl/irrigation_pkg.sv
// Shared definitions for the irrigation controller: state codes, valve-mode codes
// and the tank-level plausibility check.
package irrigation_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    FILL     = 2'b01,
    IRRIGATE = 2'b10,
    ERROR    = 2'b11
  } state_e;

  localparam logic DRIP      = 1'b0;
  localparam logic SPRINKLER = 1'b1;

  // Sensor vector layout, MSB first: {H, M, L, US, UA}
  localparam int SENS_W = 5;

  // A higher level switch may never be wet while a lower one is dry.
  function automatic logic level_fault(input logic h, input logic m, input logic l);
    return (h & ~m) | (m & ~l) | (h & ~l);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/irr_sensor_sync.sv
// Two-flop synchronizer for the sensor vector; with SENSOR_DEBOUNCE_EN defined the
// synchronized vector must also hold steady for DEB_CYCLES cycles before it is passed on.
module irr_sensor_sync
  import irrigation_pkg::*;
#(
  parameter int WIDTH      = SENS_W,
  parameter int DEB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Metastability chain on the raw sensor pins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
    end
  end

`ifdef SENSOR_DEBOUNCE_EN
  localparam int DCW = $clog2(DEB_CYCLES + 1);
  localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_CYCLES - 1);

  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [DCW-1:0]   cnt_q, cnt_d;

  // Any change restarts the stability count; a full count accepts the vector
  always_comb begin
    prev_d   = sync_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync_q != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q < DEB_LAST) begin
      cnt_d = cnt_q + DCW'(1);
    end else begin
      stable_d = sync_q;
    end
  end

  // Debounce state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      prev_q   <= prev_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout = stable_q;
`else
  assign dout = sync_q;
`endif

endmodule

// File: rtl/irrigation_ctrl_fsm.sv
// Irrigation controller: fill / irrigate / fault FSM with burst timer and rest period.
// Optional macro SENSOR_DEBOUNCE_EN adds a sensor debounce stage in irr_sensor_sync.
module irrigation_ctrl_fsm
  import irrigation_pkg::*;
#(
  parameter int TIMER_CYCLES = 16,
  parameter int REST_CYCLES  = 8,
  parameter int DEB_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       H,
  input  logic       M,
  input  logic       L,
  input  logic       US,
  input  logic       UA,
  output logic [1:0] STATE,
  output logic       VE,
  output logic       VA,
  output logic       VG,
  output logic       ALARM,
  output logic       T
);

  localparam int CW = $clog2(max_int(TIMER_CYCLES, REST_CYCLES) + 1);
  localparam logic [CW-1:0] TIMER_LOAD = CW'(TIMER_CYCLES - 1);
  localparam logic [CW-1:0] REST_LOAD  = CW'(REST_CYCLES);
  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  logic [SENS_W-1:0] sens_raw_s;
  logic [SENS_W-1:0] sens_s;
  logic h_s, m_s, l_s, us_s, ua_s;

  assign sens_raw_s = {H, M, L, US, UA};

  irr_sensor_sync #(
    .WIDTH      (SENS_W),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_sensor_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (sens_raw_s),
    .dout    (sens_s)
  );

  assign {h_s, m_s, l_s, us_s, ua_s} = sens_s;

  state_e        state_q, state_d;
  logic [CW-1:0] timer_q, timer_d;
  logic [CW-1:0] rest_q, rest_d, rest_dec_s;
  logic          mode_q, mode_d;
  logic          ve_q, ve_d, va_q, va_d, vg_q, vg_d;
  logic          alarm_q, alarm_d, t_q, t_d;

  // Next-state, counters and output decode from the next state
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    mode_d  = mode_q;
    t_d     = 1'b0;
    if (rest_q == CNT_ZERO) begin
      rest_dec_s = CNT_ZERO;
    end else begin
      rest_dec_s = rest_q - CNT_ONE;
    end
    // The rest period only elapses while idle; restart is allowed on the
    // cycle it runs out, so IDLE lasts exactly REST_CYCLES cycles.
    if (state_q == IDLE) begin
      rest_d = rest_dec_s;
    end else begin
      rest_d = rest_q;
    end

    if (level_fault(h_s, m_s, l_s)) begin
      state_d = ERROR;
    end else begin
      case (state_q)
        IDLE: begin
          if (!l_s) begin
            state_d = FILL;
          end else if (!us_s && (rest_dec_s == CNT_ZERO)) begin
            state_d = IRRIGATE;
            timer_d = TIMER_LOAD;
            mode_d  = ua_s;
          end else begin
            state_d = IDLE;
          end
        end
        FILL: begin
          if (h_s) begin
            state_d = IDLE;
          end else begin
            state_d = FILL;
          end
        end
        IRRIGATE: begin
          if (!l_s) begin
            state_d = FILL;
          end else if (us_s) begin
            state_d = IDLE;
          end else if (timer_q == CNT_ZERO) begin
            state_d = IDLE;
            t_d     = 1'b1;
            rest_d  = REST_LOAD;
          end else begin
            timer_d = timer_q - CNT_ONE;
          end
        end
        ERROR: begin
          state_d = IDLE;
          rest_d  = CNT_ZERO;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    ve_d    = (state_d == FILL);
    va_d    = (state_d == IRRIGATE) && (mode_d == SPRINKLER);
    vg_d    = (state_d == IRRIGATE) && (mode_d == DRIP);
    alarm_d = (state_d == ERROR);
  end

  // State, counters and registered actuator outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      timer_q <= CNT_ZERO;
      rest_q  <= CNT_ZERO;
      mode_q  <= DRIP;
      ve_q    <= 1'b0;
      va_q    <= 1'b0;
      vg_q    <= 1'b0;
      alarm_q <= 1'b0;
      t_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      rest_q  <= rest_d;
      mode_q  <= mode_d;
      ve_q    <= ve_d;
      va_q    <= va_d;
      vg_q    <= vg_d;
      alarm_q <= alarm_d;
      t_q     <= t_d;
    end
  end

  assign STATE = state_q;
  assign VE    = ve_q;
  assign VA    = va_q;
  assign VG    = vg_q;
  assign ALARM = alarm_q;
  assign T     = t_q;

endmodule
